// File: rtl/victim_writeback_buffer.sv
// Victim writeback buffer: FIFO of dirty evicted lines drained to the next memory level,
// with a registered associative snoop lookup across all occupied entries.
module victim_writeback_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 50,
    parameter int unsigned BLOCK_W = 512,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               evict_valid,
    input  logic [ADDR_W-1:0]  evict_addr,
    input  logic [BLOCK_W-1:0] evict_data,
    output logic               evict_ready,
    output logic               mem_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_data,
    input  logic               mem_ready,
    input  logic               snoop_valid,
    input  logic [ADDR_W-1:0]  snoop_addr,
    output logic               snoop_hit,
    output logic [BLOCK_W-1:0] snoop_data,
    output logic [CNT_W-1:0]   count,
    output logic               overflow
);

    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [BLOCK_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               snoop_hit_q, snoop_hit_d;
    logic [BLOCK_W-1:0] snoop_data_q, snoop_data_d;
    logic [PTR_W-1:0]   snoop_idx;
    logic               enq, deq;

    // Handshakes; ready depends only on registered count
    assign evict_ready = (count_q != CNT_W'(DEPTH));
    assign mem_valid   = (count_q != '0);
    assign enq         = evict_valid && evict_ready;
    assign deq         = mem_valid && mem_ready;

    // Head entry straight from storage, forced to zero when empty
    assign mem_addr   = mem_valid ? addr_q[head_q] : '0;
    assign mem_data   = mem_valid ? data_q[head_q] : '0;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign snoop_hit  = snoop_hit_q;
    assign snoop_data = snoop_data_q;

    // Next-state for pointers, occupancy, valid bits and the sticky overflow flag
    always_comb begin
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (evict_valid & ~evict_ready);
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Snoop compare on pre-edge state; walking oldest to youngest lets the youngest match win
    always_comb begin
        snoop_hit_d  = 1'b0;
        snoop_data_d = '0;
        snoop_idx    = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            snoop_idx = head_q + PTR_W'(i);
            if (snoop_valid && valid_q[snoop_idx] && (addr_q[snoop_idx] == snoop_addr)) begin
                snoop_hit_d  = 1'b1;
                snoop_data_d = data_q[snoop_idx];
            end
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            snoop_hit_q  <= 1'b0;
            snoop_data_q <= '0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            snoop_hit_q  <= snoop_hit_d;
            snoop_data_q <= snoop_data_d;
        end
    end

    // Entry storage; contents are don't-care until the valid bit is set
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            addr_q[tail_q] <= evict_addr;
            data_q[tail_q] <= evict_data;
        end
    end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Scoreboard bench for victim_writeback_buffer: a queue-based reference model updates on each
// rising edge, and a monitor on the falling edge compares DUT outputs against it.
module tb_victim_writeback_buffer;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 50;
    localparam int BLOCK_W = 512;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk;
    logic               reset;
    logic               evict_valid;
    logic [ADDR_W-1:0]  evict_addr;
    logic [BLOCK_W-1:0] evict_data;
    logic               evict_ready;
    logic               mem_valid;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_data;
    logic               mem_ready;
    logic               snoop_valid;
    logic [ADDR_W-1:0]  snoop_addr;
    logic               snoop_hit;
    logic [BLOCK_W-1:0] snoop_data;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [ADDR_W-1:0]  m_addr [$];
    logic [BLOCK_W-1:0] m_data [$];
    logic               m_ovf = 1'b0;
    // Expected snoop results, one per clock edge
    logic               exp_hit [$];
    logic [BLOCK_W-1:0] exp_sdata [$];

    victim_writeback_buffer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .evict_valid (evict_valid),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .evict_ready (evict_ready),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .snoop_hit   (snoop_hit),
        .snoop_data  (snoop_data),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                         input logic [BLOCK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] rand_blk();
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < BLOCK_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: FIFO semantics computed from the input rules at each rising edge
    initial begin
        logic               hit;
        logic [BLOCK_W-1:0] sd;
        logic               full;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_addr.delete();
                m_data.delete();
                m_ovf = 1'b0;
                exp_hit.push_back(1'b0);
                exp_sdata.push_back('0);
            end else begin
                hit = 1'b0;
                sd  = '0;
                for (int i = 0; i < m_addr.size(); i++) begin
                    if (snoop_valid && m_addr[i] == snoop_addr) begin
                        hit = 1'b1;
                        sd  = m_data[i];
                    end
                end
                exp_hit.push_back(hit);
                exp_sdata.push_back(sd);
                full = (m_addr.size() == DEPTH);
                if (evict_valid && full) m_ovf = 1'b1;
                if (mem_ready && m_addr.size() != 0) begin
                    void'(m_addr.pop_front());
                    void'(m_data.pop_front());
                end
                if (evict_valid && !full) begin
                    m_addr.push_back(evict_addr);
                    m_data.push_back(evict_data);
                end
            end
        end
    end

    // Monitor: compares DUT against the model away from the active edge
    initial begin
        logic               h;
        logic [BLOCK_W-1:0] d;
        forever begin
            @(negedge clk);
            check("count", BLOCK_W'(count), BLOCK_W'(m_addr.size()));
            check("mem_valid", BLOCK_W'(mem_valid), BLOCK_W'(m_addr.size() != 0));
            check("evict_ready", BLOCK_W'(evict_ready), BLOCK_W'(m_addr.size() != DEPTH));
            check("overflow", BLOCK_W'(overflow), BLOCK_W'(m_ovf));
            if (m_addr.size() != 0) begin
                check("mem_addr", BLOCK_W'(mem_addr), BLOCK_W'(m_addr[0]));
                check("mem_data", mem_data, m_data[0]);
            end else begin
                check("mem_addr_empty", BLOCK_W'(mem_addr), '0);
                check("mem_data_empty", mem_data, '0);
            end
            if (exp_hit.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snoop_queue at %0t: got empty expected an entry", $time);
            end else begin
                h = exp_hit.pop_front();
                d = exp_sdata.pop_front();
                check("snoop_hit", BLOCK_W'(snoop_hit), BLOCK_W'(h));
                check("snoop_data", snoop_data, d);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        evict_valid = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        mem_ready   = 1'b0;
        snoop_valid = 1'b0;
        snoop_addr  = '0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
        evict_valid = 1'b1;
        evict_addr  = a;
        evict_data  = d;
        cyc();
        evict_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [BLOCK_W-1:0] blk;
        idle_inputs();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(2);

        // Fill with memory stalled, then overflow attempt, then drain
        for (int i = 1; i <= 4; i++) begin
            blk = BLOCK_W'(32'hA0 + i);
            push(ADDR_W'(i), blk);
        end
        cyc(3);
        push(ADDR_W'(9), rand_blk());
        cyc(2);
        mem_ready = 1'b1;
        cyc(4);
        mem_ready = 1'b0;
        cyc(3);
        pulse_reset();
        cyc();

        // Steady state at count=2 with simultaneous enqueue and dequeue across pointer wrap
        push(ADDR_W'(16'h100), rand_blk());
        push(ADDR_W'(16'h101), rand_blk());
        mem_ready   = 1'b1;
        evict_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            evict_addr = ADDR_W'(16'h102 + k);
            evict_data = rand_blk();
            cyc();
        end
        evict_valid = 1'b0;
        cyc(3);
        mem_ready = 1'b0;

        // Snoop: duplicate addresses, a miss, and a hit on the entry dequeued this cycle
        push(ADDR_W'(5), rand_blk());
        push(ADDR_W'(5), rand_blk());
        snoop_valid = 1'b1;
        snoop_addr  = ADDR_W'(5);
        cyc();
        snoop_addr  = ADDR_W'(7);
        cyc();
        snoop_addr  = ADDR_W'(5);
        mem_ready   = 1'b1;
        cyc();
        snoop_addr  = ADDR_W'(5);
        cyc();
        snoop_valid = 1'b0;
        mem_ready   = 1'b0;
        cyc(2);

        // Reset with three entries pending
        push(ADDR_W'(16'h21), rand_blk());
        push(ADDR_W'(16'h22), rand_blk());
        push(ADDR_W'(16'h23), rand_blk());
        pulse_reset();
        snoop_valid = 1'b1;
        snoop_addr  = ADDR_W'(16'h21);
        cyc();
        snoop_valid = 1'b0;
        cyc();

        // Random traffic with a narrow address range so snoops hit often
        for (int k = 0; k < 600; k++) begin
            evict_valid = ($urandom_range(0, 99) < 55);
            evict_addr  = ADDR_W'($urandom_range(0, 7));
            evict_data  = rand_blk();
            mem_ready   = ($urandom_range(0, 99) < 45);
            snoop_valid = ($urandom_range(0, 99) < 60);
            snoop_addr  = ADDR_W'($urandom_range(0, 7));
            reset       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        idle_inputs();
        reset = 1'b0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
